// File: rtl/ucircuit_pkg.sv
// Shared definitions for the datapath circuit library:
// transaction mode encodings and overflow helpers.
package ucircuit_pkg;

    typedef enum logic [1:0] {
        MODE_ADD   = 2'b00,
        MODE_ACC   = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(
        input logic x_msb,
        input logic y_msb,
        input logic s_msb
    );
        return (x_msb == y_msb) && (s_msb != x_msb);
    endfunction

    function automatic logic unsigned_ovf(input logic carry);
        return carry;
    endfunction

    function automatic logic mode_loads_sum(input mode_e m);
        return (m == MODE_ADD) || (m == MODE_LOAD);
    endfunction

endpackage

// File: rtl/ucircuit_sat_add.sv
// Combinational DATAWIDTH adder returning the wrapped sum,
// the overflow flag and the value to clamp to on overflow.
module ucircuit_sat_add
    import ucircuit_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int SIGNED    = 0
) (
    input  logic [DATAWIDTH-1:0] x,
    input  logic [DATAWIDTH-1:0] y,
    output logic [DATAWIDTH-1:0] sum,
    output logic                 ovf,
    output logic [DATAWIDTH-1:0] sat
);

    logic                 carry;
    logic [DATAWIDTH-1:0] pos_max;
    logic [DATAWIDTH-1:0] neg_min;

    always_comb begin
        pos_max = {1'b0, {(DATAWIDTH-1){1'b1}}};
        neg_min = {1'b1, {(DATAWIDTH-1){1'b0}}};
        {carry, sum} = {1'b0, x} + {1'b0, y};
        if (SIGNED != 0) begin
            ovf = signed_ovf(x[DATAWIDTH-1], y[DATAWIDTH-1],
                             sum[DATAWIDTH-1]);
            // Direction of a signed overflow follows the operand sign.
            sat = x[DATAWIDTH-1] ? neg_min : pos_max;
        end else begin
            ovf = unsigned_ovf(carry);
            sat = '1;
        end
    end

endmodule

// File: rtl/ucircuit_accum.sv
// Widening adder/accumulator: stage 1 extends and adds a+b,
// stage 2 registers the sum or folds it into the accumulator.
module ucircuit_accum
    import ucircuit_pkg::*;
#(
    parameter int AWIDTH    = 8,
    parameter int BWIDTH    = 16,
    parameter int DATAWIDTH = 32,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic [AWIDTH-1:0]    a,
    input  logic [BWIDTH-1:0]    b,
    output logic [DATAWIDTH-1:0] c,
    output logic                 out_valid,
    output logic                 ovf
);

    localparam int MAXW = (AWIDTH > BWIDTH) ? AWIDTH : BWIDTH;
    localparam int APAD = DATAWIDTH - AWIDTH;
    localparam int BPAD = DATAWIDTH - BWIDTH;

    generate
        if (DATAWIDTH <= MAXW) begin : g_bad_width
            $fatal(1, "ucircuit_accum: DATAWIDTH must exceed operand widths");
        end
    endgenerate

    logic                 a_fill;
    logic                 b_fill;
    logic [DATAWIDTH-1:0] a_ext;
    logic [DATAWIDTH-1:0] b_ext;

    logic                 s1_valid_q, s1_valid_d;
    mode_e                s1_mode_q,  s1_mode_d;
    logic [DATAWIDTH-1:0] s1_sum_q,   s1_sum_d;

    logic [DATAWIDTH-1:0] c_q,         c_d;
    logic                 ovf_q,       ovf_d;
    logic                 out_valid_q, out_valid_d;

    logic [DATAWIDTH-1:0] acc_sum;
    logic                 acc_ovf;
    logic [DATAWIDTH-1:0] acc_sat;

    // Width margin guarantees a_ext + b_ext cannot overflow.
    always_comb begin
        a_fill = (SIGNED != 0) ? a[AWIDTH-1] : 1'b0;
        b_fill = (SIGNED != 0) ? b[BWIDTH-1] : 1'b0;
        a_ext  = {{APAD{a_fill}}, a};
        b_ext  = {{BPAD{b_fill}}, b};
    end

    always_comb begin
        s1_valid_d = in_valid;
        s1_mode_d  = s1_mode_q;
        s1_sum_d   = s1_sum_q;
        if (in_valid) begin
            s1_mode_d = mode_e'(mode);
            s1_sum_d  = a_ext + b_ext;
        end
    end

    ucircuit_sat_add #(
        .DATAWIDTH (DATAWIDTH),
        .SIGNED    (SIGNED)
    ) u_acc_add (
        .x   (c_q),
        .y   (s1_sum_q),
        .sum (acc_sum),
        .ovf (acc_ovf),
        .sat (acc_sat)
    );

    always_comb begin
        c_d         = c_q;
        ovf_d       = ovf_q;
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            unique case (s1_mode_q)
                MODE_ADD, MODE_LOAD: begin
                    c_d   = s1_sum_q;
                    ovf_d = 1'b0;
                end
                MODE_ACC: begin
                    c_d   = (SATURATE != 0 && acc_ovf) ? acc_sat : acc_sum;
                    ovf_d = acc_ovf;
                end
                MODE_CLEAR: begin
                    c_d   = '0;
                    ovf_d = 1'b0;
                end
                default: begin
                    c_d   = c_q;
                    ovf_d = ovf_q;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= MODE_ADD;
            s1_sum_q    <= '0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_sum_q    <= s1_sum_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign c         = c_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ucircuit_accum.sv
// Bench for ucircuit_accum: four parameterisations driven in lockstep,
// checked against an arithmetic model through a scoreboard queue.
module tb_ucircuit_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  mode;
    logic [7:0]  a;
    logic [15:0] b;

    logic [31:0] c0;
    logic [16:0] c1, c2, c3;
    logic        ov0, ov1, ov2, ov3;
    logic        vo0, vo1, vo2, vo3;

    always #5 clk = ~clk;

    ucircuit_accum u_d0 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .mode(mode),
        .a(a), .b(b), .c(c0), .out_valid(vo0), .ovf(ov0)
    );
    ucircuit_accum #(.DATAWIDTH(17)) u_d1 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .mode(mode),
        .a(a), .b(b), .c(c1), .out_valid(vo1), .ovf(ov1)
    );
    ucircuit_accum #(.DATAWIDTH(17), .SATURATE(1)) u_d2 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .mode(mode),
        .a(a), .b(b), .c(c2), .out_valid(vo2), .ovf(ov2)
    );
    ucircuit_accum #(.DATAWIDTH(17), .SIGNED(1), .SATURATE(1)) u_d3 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .mode(mode),
        .a(a), .b(b), .c(c3), .out_valid(vo3), .ovf(ov3)
    );

    typedef struct {
        int               due;
        logic [3:0][31:0] c;
        logic [3:0]       o;
    } exp_t;

    exp_t             sb[$];
    logic [3:0][31:0] macc;
    logic [3:0][31:0] hold_c;
    logic [3:0]       hold_o;
    int               cyc = 0;
    int               tests = 0;
    int               fails = 0;

    int cfg_dw [4] = '{32, 17, 17, 17};
    bit cfg_sg [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bit cfg_st [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    task automatic chk(input string tag, input logic [32:0] obs,
                       input logic [32:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // Exact-integer reference: returns {ovf, c}.
    function automatic logic [32:0] mdl(input int dw, input bit sg,
                                        input bit st, input logic [1:0] m,
                                        input logic [7:0] av,
                                        input logic [15:0] bv,
                                        input logic [31:0] acc);
        longint modv, hi, lo, ea, eb, s1, accv, tot, rv;
        logic   ov;
        modv = longint'(1) << dw;
        hi   = sg ? (modv >> 1) - 1 : modv - 1;
        lo   = sg ? -(modv >> 1) : 0;
        ea   = sg ? longint'($signed(av)) : longint'(av);
        eb   = sg ? longint'($signed(bv)) : longint'(bv);
        s1   = ea + eb;
        ov   = 1'b0;
        tot  = s1;
        if (m == 2'b11) tot = 0;
        if (m == 2'b01) begin
            accv = longint'(acc);
            if (sg && accv > hi) accv = accv - modv;
            tot = accv + s1;
            ov  = (tot > hi) || (tot < lo);
        end
        rv = tot;
        if (ov && st) rv = (tot > hi) ? hi : lo;
        rv = rv & (modv - 1);
        return {ov, rv[31:0]};
    endfunction

    task automatic tick();
        logic [3:0]       vv;
        logic [3:0]       want;
        logic [3:0][31:0] cv;
        logic [3:0]       ovv;
        exp_t             e;
        @(posedge clk);
        #1;
        cyc++;
        vv    = {vo3, vo2, vo1, vo0};
        ovv   = {ov3, ov2, ov1, ov0};
        cv[0] = c0;
        cv[1] = {15'b0, c1};
        cv[2] = {15'b0, c2};
        cv[3] = {15'b0, c3};
        want  = (sb.size() > 0 && sb[0].due == cyc) ? 4'hF : 4'h0;
        chk("out_valid", {29'b0, vv}, {29'b0, want});
        if (want != 4'h0) begin
            e      = sb.pop_front();
            hold_c = e.c;
            hold_o = e.o;
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("c%0d", i), {1'b0, cv[i]}, {1'b0, hold_c[i]});
            chk($sformatf("ovf%0d", i), {32'b0, ovv[i]},
                {32'b0, hold_o[i]});
        end
    endtask

    task automatic issue(input logic [1:0] m, input logic [7:0] av,
                         input logic [15:0] bv);
        exp_t        e;
        logic [32:0] r;
        in_valid = 1'b1;
        mode     = m;
        a        = av;
        b        = bv;
        e.due    = cyc + 2;
        for (int i = 0; i < 4; i++) begin
            r       = mdl(cfg_dw[i], cfg_sg[i], cfg_st[i], m, av, bv,
                          macc[i]);
            e.c[i]  = r[31:0];
            e.o[i]  = r[32];
            macc[i] = r[31:0];
        end
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic flush_model();
        sb.delete();
        macc   = '0;
        hold_c = '0;
        hold_o = '0;
    endtask

    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_ACC = 2'b01;
    localparam logic [1:0] M_LD  = 2'b10;
    localparam logic [1:0] M_CLR = 2'b11;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        mode     = 2'b00;
        a        = '0;
        b        = '0;
        flush_model();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_c0", {1'b0, c0}, 33'h0);
        chk("rst_v0", {32'b0, vo0}, 33'h0);

        // ADD with all-ones operands widens without overflow
        issue(M_ADD, 8'hFF, 16'hFFFF);
        tick();
        chk("t1_c", {1'b0, c0}, 33'h0_0001_00FE);
        chk("t1_v", {32'b0, vo0}, 33'h1);
        chk("t1_o", {32'b0, ov0}, 33'h0);

        // Back-to-back LOAD then ACC
        issue(M_LD, 8'd1, 16'd2);
        issue(M_ACC, 8'd3, 16'd4);
        chk("t2_load", {1'b0, c0}, 33'd3);
        tick();
        chk("t2_acc", {1'b0, c0}, 33'd10);

        // 17-bit unsigned wrap / saturate, signed on u_d3 too
        issue(M_LD, 8'hFF, 16'hFFFF);
        issue(M_ACC, 8'hFF, 16'hFFFF);
        tick();
        chk("t3_wrap_c", {16'b0, c1}, {16'b0, 17'h001FC});
        chk("t3_wrap_o", {32'b0, ov1}, 33'h1);
        chk("t3_sat_c", {16'b0, c2}, {16'b0, 17'h1FFFF});
        chk("t3_sat_o", {32'b0, ov2}, 33'h1);

        // Signed negative overflow clamps to the most negative value
        issue(M_LD, 8'h80, 16'h8000);
        issue(M_ACC, 8'h80, 16'h8000);
        tick();
        chk("t4_c", {16'b0, c3}, {16'b0, 17'h10000});
        chk("t4_o", {32'b0, ov3}, 33'h1);

        // Accumulate to 50, idle, clear, accumulate again
        issue(M_CLR, 8'h55, 16'h1234);
        for (int k = 0; k < 5; k++) issue(M_ACC, 8'd10, 16'd0);
        tick();
        chk("t5_50", {1'b0, c0}, 33'd50);
        tick();
        tick();
        tick();
        chk("t5_hold", {1'b0, c0}, 33'd50);
        issue(M_CLR, 8'd7, 16'd9);
        issue(M_ACC, 8'd5, 16'd0);
        chk("t5_clr", {1'b0, c0}, 33'd0);
        tick();
        chk("t5_5", {1'b0, c0}, 33'd5);

        // Mixed signed stream with positive saturation on u_d3
        issue(M_LD, 8'h7F, 16'h7FFF);
        issue(M_ACC, 8'h7F, 16'h7FFF);
        issue(M_ACC, 8'hC3, 16'h0100);
        issue(M_ADD, 8'h12, 16'hF000);
        tick();
        tick();

        // Reset while an ACC is in flight discards it
        issue(M_ACC, 8'd3, 16'd4);
        rst = 1'b1;
        flush_model();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_c", {1'b0, c0}, 33'h0);
        chk("t6_v", {32'b0, vo0}, 33'h0);
        chk("t6_o", {32'b0, ov0}, 33'h0);
        chk("sb_empty", {1'b0, 32'(sb.size())}, 33'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
